// File: rtl/half_adder_gate_unit.sv
// Registered WIDTH-lane AND / XOR / half-add / ripple-add unit built from AND and XOR gate cells,
// with a single-entry valid/ready output register.

module hagu_and_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = x_i & y_i;
endmodule

module hagu_xor_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = x_i ^ y_i;
endmodule

module hagu_half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    hagu_xor_cell #(.WIDTH(1)) u_xor (.x_i(a_i), .y_i(b_i), .z_o(s_o));
    hagu_and_cell #(.WIDTH(1)) u_and (.x_i(a_i), .y_i(b_i), .z_o(c_o));
endmodule

module half_adder_gate_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             carry_out
);
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_XOR  = 2'b01,
        OP_HADD = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    logic [WIDTH-1:0] and_v, xor_v, add_s, add_c;
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_d, carry_d, sum_q, carry_q;
    logic             cout_d, cout_q, valid_q, accept;

    hagu_and_cell #(.WIDTH(WIDTH)) u_and (.x_i(a), .y_i(b), .z_o(and_v));
    hagu_xor_cell #(.WIDTH(WIDTH)) u_xor (.x_i(a), .y_i(b), .z_o(xor_v));

    // chain[i] is the carry into lane i; each lane is two chained half adders
    assign chain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic s1, c1, c2;
        hagu_half_adder u_ha1 (.a_i(a[i]), .b_i(b[i]),     .s_o(s1),       .c_o(c1));
        hagu_half_adder u_ha2 (.a_i(s1),   .b_i(chain[i]), .s_o(add_s[i]), .c_o(c2));
        assign chain[i+1] = c1 | c2;
        assign add_c[i]   = chain[i+1];
    end

    always_comb begin
        sum_d   = '0;
        carry_d = '0;
        cout_d  = 1'b0;
        case (op_e'(op))
            OP_AND:  sum_d = and_v;
            OP_XOR:  sum_d = xor_v;
            OP_HADD: begin
                sum_d   = xor_v;
                carry_d = and_v;
            end
            OP_ADD: begin
                sum_d   = add_s;
                carry_d = add_c;
                cout_d  = chain[WIDTH];
            end
            default: ;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign carry_out = cout_q;
endmodule

// File: tb/tb_half_adder_gate_unit.sv
// Directed + random scoreboard bench for half_adder_gate_unit at WIDTH=4 and WIDTH=1.

module tb_half_adder_gate_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv4, ir4, ov4, or4, co4;
    logic [3:0] a4, b4, s4, c4;
    logic [1:0] op4;

    logic       iv1, ir1, ov1, or1, co1;
    logic [0:0] a1, b1, s1, c1;
    logic [1:0] op1;

    half_adder_gate_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .carry(c4), .carry_out(co4)
    );

    half_adder_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .carry_out(co1)
    );

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] c;
        logic       co;
    } res_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] s;
        logic [3:0] c;
        logic       co;
    } vec_t;

    res_t q4[$];
    res_t q1[$];

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    vec_t vt[5] = '{
        '{a:4'b1011, b:4'b0110, op:2'b00, s:4'b0010, c:4'b0000, co:1'b0},
        '{a:4'b1011, b:4'b0110, op:2'b01, s:4'b1101, c:4'b0000, co:1'b0},
        '{a:4'b1011, b:4'b0110, op:2'b10, s:4'b1101, c:4'b0010, co:1'b0},
        '{a:4'b1111, b:4'b0001, op:2'b11, s:4'b0000, c:4'b1111, co:1'b1},
        '{a:4'b0101, b:4'b0011, op:2'b11, s:4'b1000, c:4'b0111, co:1'b0}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: lane carry i is bit i+1 of the sum of the low i+1 bits
    function automatic res_t model(input int unsigned w, input logic [3:0] a,
                                   input logic [3:0] b, input logic [1:0] op);
        res_t       r;
        logic [4:0] full;
        logic [3:0] m;
        logic [3:0] wm;
        r  = '0;
        wm = 4'((1 << w) - 1);
        case (op)
            2'b00: r.s = a & b;
            2'b01: r.s = a ^ b;
            2'b10: begin
                r.s = a ^ b;
                r.c = a & b;
            end
            default: begin
                full = {1'b0, a} + {1'b0, b};
                r.s  = full[3:0];
                r.co = full[w];
                for (int unsigned i = 0; i < w; i++) begin
                    m      = 4'((1 << (i + 1)) - 1);
                    full   = {1'b0, a & m} + {1'b0, b & m};
                    r.c[i] = full[i+1];
                end
            end
        endcase
        r.s = r.s & wm;
        r.c = r.c & wm;
        return r;
    endfunction

    task automatic check4(input string tag);
        res_t e;
        chk({tag, ".valid"}, ov4, 1);
        chk({tag, ".sb"}, (q4.size() != 0), 1);
        if (q4.size() != 0) begin
            e = q4.pop_front();
            chk({tag, ".sum"}, s4, e.s);
            chk({tag, ".carry"}, c4, e.c);
            chk({tag, ".cout"}, co4, e.co);
        end
    endtask

    task automatic check1(input string tag);
        res_t e;
        chk({tag, ".valid"}, ov1, 1);
        chk({tag, ".sb"}, (q1.size() != 0), 1);
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk({tag, ".sum"}, s1, e.s);
            chk({tag, ".carry"}, c1, e.c);
            chk({tag, ".cout"}, co1, e.co);
        end
    endtask

    initial begin
        logic [3:0] hs;
        logic [3:0] hc;
        logic [3:0] ra, rb;
        logic [1:0] rop;
        hs = 4'b0110;
        hc = 4'b1000;

        rst = 1'b1;
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; op4 = 2'b11; or4 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; op1 = 2'b00; or1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.valid4", ov4, 0);
        chk("rst.sum4", s4, 0);
        chk("rst.carry4", c4, 0);
        chk("rst.cout4", co4, 0);
        chk("rst.in_ready4", ir4, 1);
        chk("rst.valid1", ov1, 0);
        iv4 = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=1 half-add truth table, one input per cycle
        for (int i = 0; i < 4; i++) begin
            a1  = 1'((i >> 1) & 1);
            b1  = 1'(i & 1);
            op1 = 2'b10;
            iv1 = 1'b1;
            chk($sformatf("ht%0d.in_ready", i), ir1, 1);
            q1.push_back('{s: {3'b000, hs[i]}, c: {3'b000, hc[i]}, co: 1'b0});
            @(negedge clk);
            check1($sformatf("ht%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            a1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            op1 = 2'($urandom_range(0, 3));
            iv1 = 1'b1;
            q1.push_back(model(1, {3'b000, a1}, {3'b000, b1}, op1));
            @(negedge clk);
            check1($sformatf("r1_%0d", i));
        end
        iv1 = 1'b0; a1 = 'x; b1 = 'x; op1 = 'x;
        @(negedge clk);
        chk("w1.drain", ov1, 0);

        // WIDTH=4 directed vectors back-to-back
        for (int i = 0; i < 5; i++) begin
            a4 = vt[i].a; b4 = vt[i].b; op4 = vt[i].op; iv4 = 1'b1;
            q4.push_back('{s: vt[i].s, c: vt[i].c, co: vt[i].co});
            @(negedge clk);
            check4($sformatf("dv%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            a4 = ra; b4 = rb; op4 = rop; iv4 = 1'b1;
            q4.push_back(model(4, ra, rb, rop));
            @(negedge clk);
            check4($sformatf("r4_%0d", i));
        end
        iv4 = 1'b0; a4 = 'x; b4 = 'x; op4 = 'x;
        @(negedge clk);
        chk("w4.drain", ov4, 0);
        chk("w4.idle_x", $isunknown({s4, c4, co4}), 0);

        // Backpressure: held result must not change while a new request waits
        a4 = 4'b0011; b4 = 4'b0101; op4 = 2'b10; iv4 = 1'b1; or4 = 1'b1;
        q4.push_back('{s: 4'b0110, c: 4'b0001, co: 1'b0});
        @(negedge clk);
        or4 = 1'b0;
        a4 = 4'b0001; b4 = 4'b0001; op4 = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.valid", k), ov4, 1);
            chk($sformatf("bp%0d.in_ready", k), ir4, 0);
            chk($sformatf("bp%0d.sum", k), s4, q4[0].s);
            chk($sformatf("bp%0d.carry", k), c4, q4[0].c);
        end
        or4 = 1'b1;
        void'(q4.pop_front());
        q4.push_back('{s: 4'b0010, c: 4'b0001, co: 1'b0});
        #1;
        chk("bp.release_in_ready", ir4, 1);
        @(negedge clk);
        check4("bp.nobubble");
        iv4 = 1'b0;

        // Reset while a result is held
        a4 = 4'b1111; b4 = 4'b0001; op4 = 2'b11; iv4 = 1'b1;
        q4.push_back('{s: 4'b0000, c: 4'b1111, co: 1'b1});
        @(negedge clk);
        check4("pre_rst");
        or4 = 1'b0;
        a4 = 4'b0111; b4 = 4'b0111;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.valid", ov4, 0);
        chk("mrst.sum", s4, 0);
        chk("mrst.carry", c4, 0);
        chk("mrst.cout", co4, 0);
        chk("mrst.in_ready", ir4, 1);
        rst = 1'b0;
        iv4 = 1'b0;
        q4.delete();
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
